// File: rtl/alu_req_issuer.sv
// Request FIFO and one-at-a-time issue sequencer feeding the ALU, with a held response register.
// Optional ALU_CMD_FILTER_EN: reject out-of-range commands locally with an error response instead of issuing.
module alu_req_issuer #(
  parameter int WIDTH = 8,
  parameter int C_W   = 4,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [WIDTH-1:0] REQ_OPA,
  input  logic [WIDTH-1:0] REQ_OPB,
  input  logic [C_W-1:0]   REQ_CMD,
  input  logic             REQ_MODE,
  input  logic             REQ_CIN,
  input  logic [1:0]       REQ_INP_VALID,
  output logic [WIDTH-1:0] OPA,
  output logic [WIDTH-1:0] OPB,
  output logic [C_W-1:0]   CMD,
  output logic             MODE,
  output logic             CIN,
  output logic             CE,
  output logic [1:0]       INP_VALID,
  input  logic [WIDTH:0]   RES,
  input  logic             ERR,
  input  logic             OFLOW,
  input  logic             COUT,
  input  logic             G,
  input  logic             L,
  input  logic             E,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [WIDTH:0]   RSP_RES,
  output logic             RSP_ERR,
  output logic             RSP_OFLOW,
  output logic             RSP_COUT,
  output logic             RSP_G,
  output logic             RSP_L,
  output logic             RSP_E
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [C_W-1:0]   cmd;
    logic             mode;
    logic             cin;
    logic [1:0]       inp_valid;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  req_t          fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          req_ready_r;
  logic          push, pop, can_pop;
  req_t          req_in, head, iss_p0;
  logic [1:0]    lat_cnt_p0;
  state_t        state, state_nxt;
  logic          cap_rsp, flt_rsp, rel_rsp;

  logic             vld_p1;
  logic [WIDTH:0]   rsp_res_p1;
  logic [5:0]       rsp_flags_p1;

  // Edges after the CE-sampling edge minus one; multiply-class ops take one extra.
  function automatic logic [1:0] lat_m1(input logic mode, input logic [C_W-1:0] cmd);
    return (mode && (cmd == C_W'(9) || cmd == C_W'(10))) ? 2'd2 : 2'd1;
  endfunction

`ifdef ALU_CMD_FILTER_EN
  function automatic logic cmd_illegal(input logic mode, input logic [C_W-1:0] cmd);
    return mode ? (cmd > C_W'(10)) : (cmd > C_W'(13));
  endfunction
`endif

  assign req_in    = '{REQ_OPA, REQ_OPB, REQ_CMD, REQ_MODE, REQ_CIN, REQ_INP_VALID};
  assign push      = REQ_VALID && req_ready_r;
  assign REQ_READY = req_ready_r;
  // An empty FIFO forwards the incoming request so an idle issuer can start on the accept edge.
  assign can_pop   = (count != '0) || push;
  assign head      = (count == '0) ? req_in : fifo_mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (!push && pop) count_nxt = count - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      req_ready_r <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count       <= count_nxt;
      req_ready_r <= (count_nxt != (AW+1)'(DEPTH));
    end
  end

  // Stage p0: FIFO storage, issue register and latency counter
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= req_in;
    if (pop)  iss_p0 <= head;
    if (state == ISSUE)
      lat_cnt_p0 <= lat_m1(iss_p0.mode, iss_p0.cmd);
    else if (state == WAIT && lat_cnt_p0 != 2'd0)
      lat_cnt_p0 <= lat_cnt_p0 - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    cap_rsp   = 1'b0;
    flt_rsp   = 1'b0;
    rel_rsp   = 1'b0;
    OPA       = '0;
    OPB       = '0;
    CMD       = '0;
    MODE      = 1'b0;
    CIN       = 1'b0;
    CE        = 1'b0;
    INP_VALID = 2'b00;
    case (state)
      IDLE: begin
        if (can_pop) begin
          pop = 1'b1;
`ifdef ALU_CMD_FILTER_EN
          if (cmd_illegal(head.mode, head.cmd)) begin
            flt_rsp   = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = ISSUE;
          end
`else
          state_nxt = ISSUE;
`endif
        end
      end
      ISSUE: begin
        OPA       = iss_p0.opa;
        OPB       = iss_p0.opb;
        CMD       = iss_p0.cmd;
        MODE      = iss_p0.mode;
        CIN       = iss_p0.cin;
        INP_VALID = iss_p0.inp_valid;
        CE        = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (lat_cnt_p0 == 2'd0) begin
          cap_rsp   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (RSP_READY) begin
          rel_rsp   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: response register, held until the consumer takes it
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p1       <= 1'b0;
      rsp_res_p1   <= '0;
      rsp_flags_p1 <= '0;
    end else if (cap_rsp) begin
      vld_p1       <= 1'b1;
      rsp_res_p1   <= RES;
      rsp_flags_p1 <= {ERR, OFLOW, COUT, G, L, E};
    end else if (flt_rsp) begin
      vld_p1       <= 1'b1;
      rsp_res_p1   <= '0;
      rsp_flags_p1 <= 6'b100000;
    end else if (rel_rsp) begin
      vld_p1       <= 1'b0;
    end
  end

  assign RSP_VALID = vld_p1;
  assign RSP_RES   = rsp_res_p1;
  assign {RSP_ERR, RSP_OFLOW, RSP_COUT, RSP_G, RSP_L, RSP_E} = rsp_flags_p1;

endmodule

// File: tb/tb_alu_req_issuer.sv
// Directed bench for alu_req_issuer: RES carries a per-edge stamp so the capture edge is observable.
module tb_alu_req_issuer;

  typedef struct packed {
    logic [7:0] opa;
    logic [7:0] opb;
    logic [3:0] cmd;
    logic       mode;
    logic       cin;
    logic [1:0] iv;
  } req_t;

  logic       CLK = 1'b0;
  logic       RST;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic [7:0] REQ_OPA, REQ_OPB;
  logic [3:0] REQ_CMD;
  logic       REQ_MODE, REQ_CIN;
  logic [1:0] REQ_INP_VALID;
  logic [7:0] OPA, OPB;
  logic [3:0] CMD;
  logic       MODE, CIN, CE;
  logic [1:0] INP_VALID;
  logic [8:0] RES;
  logic       ERR, OFLOW, COUT, G, L, E;
  logic       RSP_VALID, RSP_READY;
  logic [8:0] RSP_RES;
  logic       RSP_ERR, RSP_OFLOW, RSP_COUT, RSP_G, RSP_L, RSP_E;

  logic [8:0] res_stamp = 9'd0;
  logic [5:0] alu_flags = 6'd0;
  int         n_chk = 0;
  int         n_bad = 0;
  int         ce_cnt = 0;
  int         rsp_cnt = 0;
  bit         mon_en = 1'b0;
  req_t       acc_q[$];

  logic [8:0]  ce_stamp = 9'd0;
  logic        prev_vld = 1'b0;
  logic [14:0] prev_rsp = 15'd0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) res_stamp <= res_stamp + 9'd1;
  assign RES = res_stamp;
  assign {ERR, OFLOW, COUT, G, L, E} = alu_flags;

  alu_req_issuer dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_OPA(REQ_OPA), .REQ_OPB(REQ_OPB), .REQ_CMD(REQ_CMD),
    .REQ_MODE(REQ_MODE), .REQ_CIN(REQ_CIN), .REQ_INP_VALID(REQ_INP_VALID),
    .OPA(OPA), .OPB(OPB), .CMD(CMD), .MODE(MODE), .CIN(CIN), .CE(CE),
    .INP_VALID(INP_VALID), .RES(RES),
    .ERR(ERR), .OFLOW(OFLOW), .COUT(COUT), .G(G), .L(L), .E(E),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RES(RSP_RES),
    .RSP_ERR(RSP_ERR), .RSP_OFLOW(RSP_OFLOW), .RSP_COUT(RSP_COUT),
    .RSP_G(RSP_G), .RSP_L(RSP_L), .RSP_E(RSP_E)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic req_t mk(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c,
                              input logic m, input logic ci, input logic [1:0] v);
    req_t r;
    r = '{a, b, c, m, ci, v};
    return r;
  endfunction

  function automatic int lat_of(input req_t r);
    return (r.mode && (r.cmd == 4'd9 || r.cmd == 4'd10)) ? 3 : 2;
  endfunction

  function automatic bit filtered(input req_t r);
`ifdef ALU_CMD_FILTER_EN
    return r.mode ? (r.cmd > 4'd10) : (r.cmd > 4'd13);
`else
    return 1'b0;
`endif
  endfunction

  // Watches the ALU bus and the response port every cycle.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (CE) begin
        ce_cnt++;
        if (acc_q.size() == 0) chk("ce_unexpected", 32'd1, 32'd0);
        else begin
          chk("bus_issue", 32'({OPA, OPB, CMD, MODE, CIN, INP_VALID}), 32'(acc_q[0]));
          chk("issue_unfiltered", 32'(filtered(acc_q[0])), 32'd0);
        end
        ce_stamp = res_stamp;
      end else begin
        chk("bus_idle", 32'({OPA, OPB, CMD, MODE, CIN, INP_VALID}), 32'd0);
      end
      if (RSP_VALID && !prev_vld) begin
        rsp_cnt++;
        if (acc_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
        else begin
          req_t r;
          r = acc_q.pop_front();
          if (filtered(r)) begin
            chk("rsp_filt", 32'({RSP_RES, RSP_ERR, RSP_OFLOW, RSP_COUT, RSP_G, RSP_L, RSP_E}),
                32'({9'd0, 6'b100000}));
          end else begin
            chk("rsp_latency", 32'(9'(res_stamp - ce_stamp)), 32'(lat_of(r) + 1));
            chk("rsp_data", 32'({RSP_RES, RSP_ERR, RSP_OFLOW, RSP_COUT, RSP_G, RSP_L, RSP_E}),
                32'({9'(ce_stamp + 9'(lat_of(r))), alu_flags}));
          end
        end
      end else if (RSP_VALID) begin
        chk("rsp_hold", 32'({RSP_RES, RSP_ERR, RSP_OFLOW, RSP_COUT, RSP_G, RSP_L, RSP_E}),
            32'(prev_rsp));
      end
      prev_vld = RSP_VALID;
      prev_rsp = {RSP_RES, RSP_ERR, RSP_OFLOW, RSP_COUT, RSP_G, RSP_L, RSP_E};
    end
  end

  // Presents one request and returns #1 after the edge that accepted it.
  task automatic send(input req_t r);
    bit ok;
    ok = 1'b0;
    {REQ_OPA, REQ_OPB, REQ_CMD, REQ_MODE, REQ_CIN, REQ_INP_VALID} = r;
    REQ_VALID = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (REQ_READY) begin
        ok = 1'b1;
        acc_q.push_back(r);
        @(posedge CLK); #1;
        break;
      end
      @(posedge CLK); #1;
    end
    REQ_VALID = 1'b0;
    chk("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_rsp(input int target, input int budget);
    for (int i = 0; i < budget && rsp_cnt < target; i++) begin
      @(posedge CLK); #1;
    end
    chk("rsp_count", 32'(rsp_cnt), 32'(target));
  endtask

  initial begin
    int   c0, r0;
    logic [8:0] t0;
    req_t six [6];

    RST = 1'b1; REQ_VALID = 1'b0; RSP_READY = 1'b0;
    {REQ_OPA, REQ_OPB, REQ_CMD, REQ_MODE, REQ_CIN, REQ_INP_VALID} = '0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    mon_en = 1'b1;
    chk("rst_req_ready", 32'(REQ_READY), 32'd0);
    chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("rst_ce", 32'(CE), 32'd0);
    chk("rst_rsp_res", 32'(RSP_RES), 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("rel_req_ready", 32'(REQ_READY), 32'd1);

    // Add, normal latency
    alu_flags = 6'b001000;
    RSP_READY = 1'b1;
    c0 = ce_cnt;
    send(mk(8'h0F, 8'h01, 4'd0, 1'b1, 1'b0, 2'b11));
    t0 = res_stamp;
    chk("t1_ce_e0", 32'(CE), 32'd1);
    @(posedge CLK); #1;
    chk("t1_ce_e1", 32'(CE), 32'd0);
    chk("t1_vld_e1", 32'(RSP_VALID), 32'd0);
    @(posedge CLK); #1;
    chk("t1_vld_e2", 32'(RSP_VALID), 32'd0);
    @(posedge CLK); #1;
    chk("t1_vld_e3", 32'(RSP_VALID), 32'd1);
    chk("t1_res", 32'(RSP_RES), 32'(9'(t0 + 9'd2)));
    chk("t1_cout", 32'(RSP_COUT), 32'd1);
    chk("t1_err", 32'(RSP_ERR), 32'd0);
    chk("t1_ce_count", 32'(ce_cnt - c0), 32'd1);
    @(posedge CLK); #1;
    chk("t1_consumed", 32'(RSP_VALID), 32'd0);

    // Multiply, one extra edge
    alu_flags = 6'b010010;
    send(mk(8'h02, 8'h03, 4'd9, 1'b1, 1'b0, 2'b11));
    t0 = res_stamp;
    repeat (3) @(posedge CLK);
    #1;
    chk("t2_vld_e3", 32'(RSP_VALID), 32'd0);
    @(posedge CLK); #1;
    chk("t2_vld_e4", 32'(RSP_VALID), 32'd1);
    chk("t2_res", 32'(RSP_RES), 32'(9'(t0 + 9'd3)));
    @(posedge CLK); #1;

    // Stall: fill FIFO behind one in-flight op, then drain in order
    alu_flags = 6'b000100;
    RSP_READY = 1'b0;
    six[0] = mk(8'h10, 8'h20, 4'd9,  1'b1, 1'b0, 2'b11);
    six[1] = mk(8'h11, 8'h21, 4'd1,  1'b1, 1'b1, 2'b01);
    six[2] = mk(8'h12, 8'h22, 4'd9,  1'b0, 1'b0, 2'b10);
    six[3] = mk(8'h13, 8'h23, 4'd10, 1'b1, 1'b1, 2'b11);
    six[4] = mk(8'h14, 8'h24, 4'd13, 1'b0, 1'b0, 2'b11);
    six[5] = mk(8'h15, 8'h25, 4'd2,  1'b1, 1'b0, 2'b11);
    c0 = ce_cnt;
    r0 = rsp_cnt;
    for (int i = 0; i < 5; i++) send(six[i]);
    chk("t3_full_ready", 32'(REQ_READY), 32'd0);
    {REQ_OPA, REQ_OPB, REQ_CMD, REQ_MODE, REQ_CIN, REQ_INP_VALID} = six[5];
    REQ_VALID = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      chk("t3_held", 32'(REQ_READY), 32'd0);
    end
    chk("t3_stalled_vld", 32'(RSP_VALID), 32'd1);
    chk("t3_stalled_cnt", 32'(rsp_cnt - r0), 32'd1);
    RSP_READY = 1'b1;
    send(six[5]);
    wait_rsp(r0 + 6, 200);
    chk("t3_queue_empty", 32'(acc_q.size()), 32'd0);
    chk("t3_ce_count", 32'(ce_cnt - c0), 32'd6);
    repeat (2) @(posedge CLK);
    #1;

    // Out-of-range command
    alu_flags = 6'b100101;
    c0 = ce_cnt;
    send(mk(8'h33, 8'h44, 4'd12, 1'b1, 1'b1, 2'b11));
    t0 = res_stamp;
`ifdef ALU_CMD_FILTER_EN
    chk("t4_ce", 32'(CE), 32'd0);
    chk("t4_vld", 32'(RSP_VALID), 32'd1);
    chk("t4_err", 32'(RSP_ERR), 32'd1);
    chk("t4_res", 32'(RSP_RES), 32'd0);
    chk("t4_flags", 32'({RSP_OFLOW, RSP_COUT, RSP_G, RSP_L, RSP_E}), 32'd0);
    repeat (4) @(posedge CLK);
    #1;
    chk("t4_ce_count", 32'(ce_cnt - c0), 32'd0);
`else
    chk("t4_ce", 32'(CE), 32'd1);
    repeat (3) @(posedge CLK);
    #1;
    chk("t4_vld", 32'(RSP_VALID), 32'd1);
    chk("t4_err", 32'(RSP_ERR), 32'd1);
    chk("t4_res", 32'(RSP_RES), 32'(9'(t0 + 9'd2)));
    chk("t4_flags", 32'({RSP_OFLOW, RSP_COUT, RSP_G, RSP_L, RSP_E}), 32'b00101);
    chk("t4_ce_count", 32'(ce_cnt - c0), 32'd1);
    repeat (2) @(posedge CLK);
    #1;
`endif

    // Reset while waiting with two entries queued
    alu_flags = 6'b000000;
    send(mk(8'hA0, 8'h01, 4'd1, 1'b0, 1'b0, 2'b11));
    send(mk(8'hA1, 8'h02, 4'd2, 1'b0, 1'b0, 2'b11));
    send(mk(8'hA2, 8'h03, 4'd3, 1'b0, 1'b0, 2'b11));
    chk("t5_wait_ce", 32'(CE), 32'd0);
    chk("t5_wait_vld", 32'(RSP_VALID), 32'd0);
    RST = 1'b1;
    @(posedge CLK); #1;
    acc_q.delete();
    chk("t5_rst_ce", 32'(CE), 32'd0);
    chk("t5_rst_vld", 32'(RSP_VALID), 32'd0);
    chk("t5_rst_ready", 32'(REQ_READY), 32'd0);
    RST = 1'b0;
    c0 = ce_cnt;
    r0 = rsp_cnt;
    @(posedge CLK); #1;
    chk("t5_rel_ready", 32'(REQ_READY), 32'd1);
    repeat (20) @(posedge CLK);
    #1;
    chk("t5_no_ce", 32'(ce_cnt - c0), 32'd0);
    chk("t5_no_rsp", 32'(rsp_cnt - r0), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
